// File: rtl/pcpu_sb_pkg.sv
// Shared definitions for the pcpu store buffer.
// Holds the FSM state encoding, the default data/address widths and the
// reference layout of one buffer entry at those default widths.
package pcpu_sb_pkg;

    localparam int SB_DATA_W_DEF = 16;
    localparam int SB_ADDR_W_DEF = 8;

    // Control FSM: idle, writing the head entry, reading memory for a
    // load miss, and the single cycle that presents the load result.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_LOAD  = 2'd2,
        S_RESP  = 2'd3
    } sb_state_e;

    // One buffer entry at the default widths. The top keeps the three fields
    // as separate parameterised arrays so that other widths work too.
    typedef struct packed {
        logic                     valid;
        logic [SB_ADDR_W_DEF-1:0] addr;
        logic [SB_DATA_W_DEF-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/pcpu_sb_match.sv
// Address compare across all store-buffer entries.
// Ports:
//   addr_i      address being looked up
//   valid_i     per-entry valid mask
//   drain_i     per-entry "currently draining" mask (excluded from hit_o)
//   ent_addr_i  per-entry address, ent_data_i per-entry data
//   head_i      index of the oldest entry (used to rank entry age)
//   hit_o       some valid, non-draining entry matches
//   hit_idx_o   index of the youngest such entry, hit_data_o its data
//   drain_hit_o the draining entry matches
module pcpu_sb_match
    import pcpu_sb_pkg::*;
#(
    parameter int DATA_W = SB_DATA_W_DEF,
    parameter int ADDR_W = SB_ADDR_W_DEF,
    parameter int DEPTH  = 4,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic [ADDR_W-1:0]             addr_i,
    input  logic [DEPTH-1:0]              valid_i,
    input  logic [DEPTH-1:0]              drain_i,
    input  logic [DEPTH-1:0][ADDR_W-1:0]  ent_addr_i,
    input  logic [DEPTH-1:0][DATA_W-1:0]  ent_data_i,
    input  logic [IDX_W-1:0]              head_i,
    output logic                          hit_o,
    output logic [IDX_W-1:0]              hit_idx_o,
    output logic [DATA_W-1:0]             hit_data_o,
    output logic                          drain_hit_o
);

    logic [IDX_W-1:0] age_s;
    logic [IDX_W-1:0] best_age_s;

    // Youngest-match search: age is the distance from the head, larger is younger.
    always_comb begin
        hit_o       = 1'b0;
        hit_idx_o   = '0;
        best_age_s  = '0;
        age_s       = '0;
        drain_hit_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            age_s = IDX_W'(i) - head_i;
            if (valid_i[i] && (ent_addr_i[i] == addr_i)) begin
                if (drain_i[i]) begin
                    drain_hit_o = 1'b1;
                end else if (!hit_o || (age_s > best_age_s)) begin
                    hit_o      = 1'b1;
                    hit_idx_o  = IDX_W'(i);
                    best_age_s = age_s;
                end else begin
                    hit_o = hit_o;
                end
            end else begin
                hit_o = hit_o;
            end
        end
        hit_data_o = ent_data_i[hit_idx_o];
    end

endmodule

// File: rtl/pcpu_store_buffer.sv
// Write-combining store buffer between the CPU data-memory stage and a
// req/ack memory port. Stores are queued (coalescing same-address stores),
// loads are forwarded from the buffer or read from memory, and the buffer
// drains in the background or on flush.
// Ports:
//   clock, reset (async, active low), enable (gates new CPU requests)
//   d_addr/d_dataout/d_we/d_re  CPU request; d_datain/d_rvalid load result
//   stall       combinational hold for the CPU
//   flush       force draining; flush_done = empty and idle
//   m_req/m_wr/m_addr/m_wdata   registered memory request, held until m_ack
//   m_ack/m_rdata               memory completion and read data
module pcpu_store_buffer
    import pcpu_sb_pkg::*;
#(
    parameter int DATA_W       = SB_DATA_W_DEF,
    parameter int ADDR_W       = SB_ADDR_W_DEF,
    parameter int DEPTH        = 4,
    parameter int DRAIN_THRESH = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_dataout,
    input  logic              d_we,
    input  logic              d_re,
    output logic [DATA_W-1:0] d_datain,
    output logic              d_rvalid,
    output logic              stall,
    input  logic              flush,
    output logic              flush_done,
    output logic              m_req,
    output logic              m_wr,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_ack,
    input  logic [DATA_W-1:0] m_rdata
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    sb_state_e                  state_q, state_d;
    logic [IDX_W-1:0]           head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic [DEPTH-1:0]           valid_q, valid_d;
    logic [DEPTH-1:0][ADDR_W-1:0] addr_q, addr_d;
    logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
    logic                       m_req_q, m_req_d, m_wr_q, m_wr_d;
    logic [ADDR_W-1:0]          m_addr_q, m_addr_d;
    logic [DATA_W-1:0]          m_wdata_q, m_wdata_d, d_datain_q, d_datain_d;
    logic                       d_rvalid_q, d_rvalid_d;

    logic [DEPTH-1:0]  drain_mask_s;
    logic              hit_s, drain_hit_s, ld_hit_s;
    logic [IDX_W-1:0]  hit_idx_s;
    logic [DATA_W-1:0] hit_data_s, ld_data_s, head_wdata_s;
    logic              full_s, load_act_s, ld_stall_s, st_try_s, st_full_s;
    logic              coalesce_s, push_s, pop_s, drain_go_s;

    assign drain_mask_s = (state_q == S_DRAIN) ?
                          ({{(DEPTH-1){1'b0}}, 1'b1} << head_q) : {DEPTH{1'b0}};

    pcpu_sb_match #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_match (
        .addr_i      (d_addr),
        .valid_i     (valid_q),
        .drain_i     (drain_mask_s),
        .ent_addr_i  (addr_q),
        .ent_data_i  (data_q),
        .head_i      (head_q),
        .hit_o       (hit_s),
        .hit_idx_o   (hit_idx_s),
        .hit_data_o  (hit_data_s),
        .drain_hit_o (drain_hit_s)
    );

    // The draining head only serves a load when nothing younger matches.
    assign ld_hit_s  = hit_s | drain_hit_s;
    assign ld_data_s = hit_s ? hit_data_s : data_q[head_q];
    assign full_s    = (count_q == CNT_W'(DEPTH));

    // In S_RESP the held d_re has already been answered and is not looked at again.
    assign load_act_s = enable & d_re & (state_q != S_RESP);
    // A load combined with a store always goes through S_RESP so the store
    // sees one clean stall-free cycle once the load is answered.
    assign ld_stall_s = load_act_s & (~ld_hit_s | d_we | (state_q == S_LOAD));
    assign st_try_s   = enable & d_we & ~load_act_s;
    // Full is judged on the registered count: a pop in the same cycle does not free a slot yet.
    assign st_full_s  = st_try_s & ~hit_s & full_s;
    assign coalesce_s = st_try_s & hit_s;
    assign push_s     = st_try_s & ~hit_s & ~full_s;
    assign pop_s      = (state_q == S_DRAIN) & m_ack;
    assign drain_go_s = enable & (count_q != '0) &
                        ((count_q >= CNT_W'(DRAIN_THRESH)) | flush);
    // A store coalescing into the head while its drain starts must reach memory.
    assign head_wdata_s = (coalesce_s && (hit_idx_s == head_q)) ? d_dataout : data_q[head_q];

    assign stall      = reset & (ld_stall_s | st_full_s);
    assign flush_done = (count_q == '0) && (state_q == S_IDLE);
    assign d_datain   = d_datain_q;
    assign d_rvalid   = d_rvalid_q;
    assign m_req      = m_req_q;
    assign m_wr       = m_wr_q;
    assign m_addr     = m_addr_q;
    assign m_wdata    = m_wdata_q;

    // Entry storage, pointers and occupancy.
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (coalesce_s) begin
            data_d[hit_idx_s] = d_dataout;
        end else if (push_s) begin
            valid_d[tail_q] = 1'b1;
            addr_d[tail_q]  = d_addr;
            data_d[tail_q]  = d_dataout;
            tail_d          = tail_q + IDX_W'(1);
        end else begin
            tail_d = tail_q;
        end
        if (pop_s) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + IDX_W'(1);
        end else begin
            head_d = head_q;
        end
        count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
    end

    // Control FSM and the registered CPU/memory-side outputs.
    always_comb begin
        state_d    = state_q;
        m_req_d    = m_req_q;
        m_wr_d     = m_wr_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        d_datain_d = d_datain_q;
        d_rvalid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (load_act_s && !ld_hit_s) begin
                    state_d  = S_LOAD;
                    m_req_d  = 1'b1;
                    m_wr_d   = 1'b0;
                    m_addr_d = d_addr;
                end else if (load_act_s && d_we) begin
                    state_d    = S_RESP;
                    d_datain_d = ld_data_s;
                    d_rvalid_d = 1'b1;
                end else begin
                    if (load_act_s) begin
                        d_datain_d = ld_data_s;
                        d_rvalid_d = 1'b1;
                    end else begin
                        d_rvalid_d = 1'b0;
                    end
                    if (drain_go_s) begin
                        state_d   = S_DRAIN;
                        m_req_d   = 1'b1;
                        m_wr_d    = 1'b1;
                        m_addr_d  = addr_q[head_q];
                        m_wdata_d = head_wdata_s;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                if (load_act_s && ld_hit_s && !d_we) begin
                    d_datain_d = ld_data_s;
                    d_rvalid_d = 1'b1;
                end else begin
                    d_rvalid_d = 1'b0;
                end
                if (m_ack) begin
                    state_d = S_IDLE;
                    m_req_d = 1'b0;
                    m_wr_d  = 1'b0;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_LOAD: begin
                if (m_ack) begin
                    state_d    = S_RESP;
                    m_req_d    = 1'b0;
                    d_datain_d = m_rdata;
                    d_rvalid_d = 1'b1;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                m_req_d = 1'b0;
                m_wr_d  = 1'b0;
            end
        endcase
    end

    // State registers; reset abandons any transaction and empties the buffer.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            valid_q    <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            m_req_q    <= 1'b0;
            m_wr_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            d_datain_q <= '0;
            d_rvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            m_req_q    <= m_req_d;
            m_wr_q     <= m_wr_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            d_datain_q <= d_datain_d;
            d_rvalid_q <= d_rvalid_d;
        end
    end

endmodule

// File: tb/tb_pcpu_store_buffer.sv
// Directed bench for pcpu_store_buffer (DEPTH=4, DRAIN_THRESH=4).
// The memory side is driven by hand: m_ack/m_rdata are set per step.
module tb_pcpu_store_buffer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable, d_we, d_re, flush, m_ack;
    logic [7:0]  d_addr, m_addr;
    logic [15:0] d_dataout, d_datain, m_wdata, m_rdata;
    logic        d_rvalid, stall, flush_done, m_req, m_wr;

    int checks   = 0;
    int failures = 0;

    pcpu_store_buffer #(
        .DATA_W       (16),
        .ADDR_W       (8),
        .DEPTH        (4),
        .DRAIN_THRESH (4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .d_addr     (d_addr),
        .d_dataout  (d_dataout),
        .d_we       (d_we),
        .d_re       (d_re),
        .d_datain   (d_datain),
        .d_rvalid   (d_rvalid),
        .stall      (stall),
        .flush      (flush),
        .flush_done (flush_done),
        .m_req      (m_req),
        .m_wr       (m_wr),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .m_ack      (m_ack),
        .m_rdata    (m_rdata)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clock = ~clock;

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Expects a drain write on the bus, acknowledges it for one cycle.
    task automatic drain_ack(input string tag, input logic [7:0] a, input logic [15:0] d);
        check_eq({tag, "_req"}, m_req, 1);
        check_eq({tag, "_wr"}, m_wr, 1);
        check_eq({tag, "_addr"}, m_addr, a);
        check_eq({tag, "_wdata"}, m_wdata, d);
        m_ack = 1'b1;
        step();
        m_ack = 1'b0;
        check_eq({tag, "_req_drop"}, m_req, 0);
    endtask

    initial begin
        enable = 1'b0; d_we = 1'b0; d_re = 1'b0; flush = 1'b0; m_ack = 1'b0;
        d_addr = 8'h00; d_dataout = 16'h0000; m_rdata = 16'h0000;
        repeat (2) @(posedge clock);
        #1;
        check_eq("rst_mreq", m_req, 0);
        check_eq("rst_rvalid", d_rvalid, 0);
        check_eq("rst_datain", d_datain, 0);
        check_eq("rst_stall", stall, 0);
        check_eq("rst_flush_done", flush_done, 1);
        check_eq("rst_count", dut.count_q, 0);
        reset = 1'b1;
        enable = 1'b1;

        // Store then forward
        d_we = 1'b1; d_addr = 8'h02; d_dataout = 16'h5BC7;
        #1 check_eq("st_stall", stall, 0);
        step();
        d_we = 1'b0;
        check_eq("st_count", dut.count_q, 1);
        d_re = 1'b1; d_addr = 8'h02;
        #1 check_eq("fwd_stall", stall, 0);
        step();
        check_eq("fwd_rvalid", d_rvalid, 1);
        check_eq("fwd_data", d_datain, 16'h5BC7);
        check_eq("fwd_mreq", m_req, 0);
        d_re = 1'b0;
        step();
        check_eq("fwd_pulse", d_rvalid, 0);
        flush = 1'b1;
        step();
        drain_ack("fl1", 8'h02, 16'h5BC7);
        flush = 1'b0;
        check_eq("fl1_done", flush_done, 1);

        // Coalesce
        d_we = 1'b1; d_addr = 8'h05; d_dataout = 16'h1111;
        step();
        d_dataout = 16'h2222;
        step();
        d_we = 1'b0;
        check_eq("coal_count", dut.count_q, 1);
        flush = 1'b1;
        step();
        drain_ack("coal", 8'h05, 16'h2222);
        check_eq("coal_done", flush_done, 1);
        step();
        step();
        check_eq("coal_one_write", m_req, 0);
        flush = 1'b0;

        // Full
        for (int i = 0; i < 4; i++) begin
            d_we = 1'b1; d_addr = 8'h10 + 8'(i); d_dataout = 16'hA010 + 16'(i);
            step();
        end
        check_eq("full_count4", dut.count_q, 4);
        d_addr = 8'h14; d_dataout = 16'hA014;
        #1 check_eq("full_stall", stall, 1);
        step();
        check_eq("full_stall_held", stall, 1);
        check_eq("full_count_held", dut.count_q, 4);
        check_eq("full_drain_req", m_req, 1);
        check_eq("full_drain_addr", m_addr, 8'h10);
        check_eq("full_drain_wdata", m_wdata, 16'hA010);
        m_ack = 1'b1;
        #1 check_eq("full_no_bypass", stall, 1);
        step();
        m_ack = 1'b0;
        check_eq("full_pop_count", dut.count_q, 3);
        check_eq("full_pop_req", m_req, 0);
        #1 check_eq("full_unstall", stall, 0);
        step();
        d_we = 1'b0;
        check_eq("full_fifth_in", dut.count_q, 4);

        // Load miss while a drain is in flight
        step();
        check_eq("lm_drain_req", m_req, 1);
        check_eq("lm_drain_addr", m_addr, 8'h11);
        d_re = 1'b1; d_addr = 8'h40;
        #1 check_eq("lm_stall", stall, 1);
        step();
        check_eq("lm_addr_stable", m_addr, 8'h11);
        check_eq("lm_wr_stable", m_wr, 1);
        m_ack = 1'b1;
        step();
        m_ack = 1'b0;
        check_eq("lm_pop_count", dut.count_q, 3);
        #1 check_eq("lm_stall_idle", stall, 1);
        step();
        check_eq("lm_rd_req", m_req, 1);
        check_eq("lm_rd_wr", m_wr, 0);
        check_eq("lm_rd_addr", m_addr, 8'h40);
        m_ack = 1'b1; m_rdata = 16'hABCD;
        step();
        m_ack = 1'b0;
        check_eq("lm_rvalid", d_rvalid, 1);
        check_eq("lm_data", d_datain, 16'hABCD);
        check_eq("lm_resp_stall", stall, 0);
        check_eq("lm_req_drop", m_req, 0);
        d_re = 1'b0;
        step();
        check_eq("lm_pulse", d_rvalid, 0);

        // Empty the buffer, then a store to the address being drained
        flush = 1'b1;
        step();
        drain_ack("fl2a", 8'h12, 16'hA012);
        step();
        drain_ack("fl2b", 8'h13, 16'hA013);
        step();
        drain_ack("fl2c", 8'h14, 16'hA014);
        flush = 1'b0;
        check_eq("fl2_done", flush_done, 1);
        d_we = 1'b1; d_addr = 8'h10; d_dataout = 16'hA5A5;
        step();
        d_we = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        check_eq("dh_req", m_req, 1);
        check_eq("dh_addr", m_addr, 8'h10);
        check_eq("dh_wdata", m_wdata, 16'hA5A5);
        d_re = 1'b1; d_addr = 8'h10;
        #1 check_eq("dh_ld_stall", stall, 0);
        step();
        check_eq("dh_ld_rvalid", d_rvalid, 1);
        check_eq("dh_ld_data", d_datain, 16'hA5A5);
        d_re = 1'b0;
        d_we = 1'b1; d_dataout = 16'h0F0F;
        #1 check_eq("dh_st_stall", stall, 0);
        step();
        d_we = 1'b0;
        check_eq("dh_push_count", dut.count_q, 2);
        m_ack = 1'b1;
        step();
        m_ack = 1'b0;
        check_eq("dh_pop_count", dut.count_q, 1);
        d_re = 1'b1;
        #1 check_eq("dh_ld2_stall", stall, 0);
        step();
        check_eq("dh_ld2_rvalid", d_rvalid, 1);
        check_eq("dh_ld2_data", d_datain, 16'h0F0F);
        d_re = 1'b0;
        step();

        // Asynchronous reset in the middle of a memory read
        d_re = 1'b1; d_addr = 8'h77;
        step();
        check_eq("ar_req", m_req, 1);
        check_eq("ar_stall", stall, 1);
        #3 reset = 1'b0;
        #1;
        check_eq("ar_req_drop", m_req, 0);
        check_eq("ar_rvalid", d_rvalid, 0);
        check_eq("ar_stall_drop", stall, 0);
        check_eq("ar_count", dut.count_q, 0);
        d_re = 1'b0;
        #2 reset = 1'b1;
        step();
        check_eq("ar_flush_done", flush_done, 1);
        check_eq("ar_req_idle", m_req, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
